// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
package mips_lsu_pkg;

    localparam int LSU_OP_W = 4;

    typedef enum logic [LSU_OP_W-1:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic is_store(input logic [LSU_OP_W-1:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [LSU_OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [LSU_OP_W-1:0] op, input logic [1:0] k);
        case (op)
            OP_LH, OP_LHU, OP_SH: return k[0];
            OP_LW, OP_SW:         return (k != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_load_align.sv
// Combinational load result formatter: lane select, extension and LWL/LWR merge.
module lsu_load_align
    import mips_lsu_pkg::*;
(
    input  logic [LSU_OP_W-1:0] i_op,
    input  logic [1:0]          i_k,
    input  logic [31:0]         i_w,
    input  logic [31:0]         i_rt_old,
    output logic [31:0]         o_rdata
);

    logic [4:0]  w_shr;
    logic [4:0]  w_shl;
    logic [31:0] w_w_shr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // w_shr = 8k selects the addressed byte; w_shl = 8(3-k) aligns it to the MSB for LWL
    assign w_shr   = {i_k, 3'b000};
    assign w_shl   = {~i_k, 3'b000};
    assign w_w_shr = i_w >> w_shr;
    assign w_byte  = w_w_shr[7:0];
    assign w_half  = i_k[1] ? i_w[31:16] : i_w[15:0];

    always_comb begin
        o_rdata = '0;
        case (i_op)
            OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_rdata = {24'd0, w_byte};
            OP_LH:   o_rdata = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_rdata = {16'd0, w_half};
            OP_LW:   o_rdata = i_w;
            OP_LWL:  o_rdata = (i_w << w_shl) | (i_rt_old & ~(32'hFFFF_FFFF << w_shl));
            OP_LWR:  o_rdata = w_w_shr | (i_rt_old & ~(32'hFFFF_FFFF >> w_shr));
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: request capture, fault check, one-cycle memory access and registered response.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int OP_W = LSU_OP_W
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [31:0]     req_rt_old,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_fault,
    output logic [31:0]     mem_address,
    output logic            mem_write,
    output logic [3:0]      mem_byte_en,
    output logic [31:0]     mem_writedata,
    input  logic [31:0]     mem_readdata
);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    logic [OP_W-1:0] r_op;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rt_old;
    logic [31:0]     r_rdata;
    logic            r_fault;
    logic            w_accept;
    logic            w_req_fault;
    logic [1:0]      w_k;
    logic [31:0]     w_load;

    assign w_accept    = req_valid && req_ready;
    assign w_req_fault = !is_legal(req_op) || is_misaligned(req_op, req_addr[1:0]);
    assign w_k         = r_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Memory outputs are gated by state so an async reset drops mem_write before the next edge
    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_address   = '0;
        mem_write     = 1'b0;
        mem_byte_en   = '0;
        mem_writedata = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) w_next = w_req_fault ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                w_next      = ST_RESP;
                mem_address = {r_addr[31:2], 2'b00};
                mem_write   = is_store(r_op);
                case (r_op)
                    OP_SB: begin
                        mem_byte_en   = 4'b0001 << w_k;
                        mem_writedata = {4{r_wdata[7:0]}};
                    end
                    OP_SH: begin
                        mem_byte_en   = w_k[1] ? 4'b1100 : 4'b0011;
                        mem_writedata = {2{r_wdata[15:0]}};
                    end
                    OP_SW: begin
                        mem_byte_en   = 4'b1111;
                        mem_writedata = r_wdata;
                    end
                    OP_LB, OP_LBU: mem_byte_en = 4'b0001 << w_k;
                    OP_LH, OP_LHU: mem_byte_en = w_k[1] ? 4'b1100 : 4'b0011;
                    OP_LW:         mem_byte_en = 4'b1111;
                    OP_LWL:        mem_byte_en = 4'b1111 >> (2'd3 - w_k);
                    OP_LWR:        mem_byte_en = 4'b1111 << w_k;
                    default:       mem_byte_en = 4'b0000;
                endcase
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= req_op;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rt_old <= req_rt_old;
        end
    end

    lsu_load_align u_load_align (
        .i_op     (r_op),
        .i_k      (w_k),
        .i_w      (mem_readdata),
        .i_rt_old (r_rt_old),
        .o_rdata  (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else if (w_accept && w_req_fault) begin
            r_rdata <= '0;
            r_fault <= 1'b1;
        end else if (r_state == ST_ACCESS) begin
            r_rdata <= is_store(r_op) ? 32'd0 : w_load;
            r_fault <= 1'b0;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_mips_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt_old;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int total = 0;
    int bad   = 0;

    mips_lsu #(.OP_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rt_old    (req_rt_old),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .mem_address   (mem_address),
        .mem_write     (mem_write),
        .mem_byte_en   (mem_byte_en),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory driven by the DUT, plus a shadow copy updated by the reference model
    logic [7:0]  mem    [0:4095];
    logic [7:0]  sh_mem [0:4095];
    logic [11:0] ma;
    assign ma = mem_address[11:0];
    assign mem_readdata = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

    always @(posedge clk) begin
        if (mem_write)
            for (int i = 0; i < 4; i++)
                if (mem_byte_en[i]) mem[ma + 12'(i)] = mem_writedata[8*i +: 8];
    end

    int          wr_cnt = 0;
    logic [31:0] wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_wd;
    always @(negedge clk) begin
        if (mem_write) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_address;
            wr_be   = mem_byte_en;
            wr_wd   = mem_writedata;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 8'h00;
            sh_mem[i] = 8'h00;
        end
        mem[12'h100] = 8'hBB; mem[12'h101] = 8'hAA; mem[12'h102] = 8'h99; mem[12'h103] = 8'h88;
        sh_mem[12'h100] = 8'hBB; sh_mem[12'h101] = 8'hAA; sh_mem[12'h102] = 8'h99; sh_mem[12'h103] = 8'h88;
    endtask

    // Architectural reference: operates on the shadow byte array directly
    function automatic void ref_model(input logic [3:0] op, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [31:0] rt,
                                      output logic [31:0] rd, output logic flt,
                                      output int lat, output int nwr);
        int a, k, b;
        logic [31:0] w;
        logic [7:0]  by;
        logic [15:0] hw;
        longint      lw, msk;
        a  = int'(addr[11:0]);
        k  = int'(addr[1:0]);
        b  = a - k;
        w  = {sh_mem[b+3], sh_mem[b+2], sh_mem[b+1], sh_mem[b]};
        by = sh_mem[a];
        hw = {sh_mem[a | 1], sh_mem[a & ~1]};
        rd  = 32'd0;
        flt = 1'b0;
        case (op)
            4'd0: rd = int'($signed(by));
            4'd1: rd = {24'd0, by};
            4'd2: if (k % 2 != 0) flt = 1'b1; else rd = int'($signed(hw));
            4'd3: if (k % 2 != 0) flt = 1'b1; else rd = {16'd0, hw};
            4'd4: if (k != 0) flt = 1'b1; else rd = w;
            4'd5: begin
                lw  = longint'(w) << (8 * (3 - k));
                msk = (longint'(1) << (8 * (3 - k))) - 1;
                rd  = 32'(lw) | (rt & 32'(msk));
            end
            4'd6: rd = (w >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
            4'd8: sh_mem[a] = wdata[7:0];
            4'd9: if (k % 2 != 0) flt = 1'b1;
                  else begin sh_mem[a] = wdata[7:0]; sh_mem[a+1] = wdata[15:8]; end
            4'd10: if (k != 0) flt = 1'b1;
                   else for (int i = 0; i < 4; i++) sh_mem[a+i] = wdata[8*i +: 8];
            default: flt = 1'b1;
        endcase
        lat = flt ? 1 : 2;
        nwr = ((op == 4'd8 || op == 4'd9 || op == 4'd10) && !flt) ? 1 : 0;
    endfunction

    task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rt,
                          output logic [31:0] rd, output logic flt,
                          output int lat, output int nwr);
        int g;
        int wc0;
        g = 0;
        while (!req_ready && g < 10) begin @(posedge clk); #1; g++; end
        req_op = op; req_addr = addr; req_wdata = wdata; req_rt_old = rt; req_valid = 1'b1;
        wc0 = wr_cnt;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_op     = 4'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rt_old = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        rd  = resp_rdata;
        flt = resp_fault;
        if (resp_ready) begin @(posedge clk); #1; end
        nwr = wr_cnt - wc0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rt;
        logic [31:0] exp_rd;
        logic        exp_f;
        int          exp_lat;
        int          exp_nwr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t tbl [17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, erd, erd2;
        logic        flt, ef;
        int          lat, el, nwr, en, wc0;

        tbl[0]  = '{4'd0,  32'h103, 32'h0,        32'h0,        32'hFFFFFF88, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[1]  = '{4'd1,  32'h103, 32'h0,        32'h0,        32'h00000088, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[2]  = '{4'd2,  32'h102, 32'h0,        32'h0,        32'hFFFF8899, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[3]  = '{4'd5,  32'h101, 32'h0,        32'h11223344, 32'hAABB3344, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[4]  = '{4'd6,  32'h102, 32'h0,        32'h11223344, 32'h11228899, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[5]  = '{4'd4,  32'h101, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 4'h0, 32'h0};
        tbl[6]  = '{4'd9,  32'h103, 32'h1234,     32'h0,        32'h0,        1'b1, 1, 0, 4'h0, 32'h0};
        tbl[7]  = '{4'd7,  32'h100, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 4'h0, 32'h0};
        tbl[8]  = '{4'd9,  32'h102, 32'h1234,     32'h0,        32'h0,        1'b0, 2, 1, 4'hC, 32'h12341234};
        tbl[9]  = '{4'd4,  32'h100, 32'h0,        32'h0,        32'h1234AABB, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[10] = '{4'd3,  32'h100, 32'h0,        32'h0,        32'h0000AABB, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[11] = '{4'd2,  32'h100, 32'h0,        32'h0,        32'hFFFFAABB, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[12] = '{4'd8,  32'h101, 32'h000000C5, 32'h0,        32'h0,        1'b0, 2, 1, 4'h2, 32'hC5C5C5C5};
        tbl[13] = '{4'd4,  32'h100, 32'h0,        32'h0,        32'h1234C5BB, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[14] = '{4'd10, 32'h104, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 2, 1, 4'hF, 32'hCAFEF00D};
        tbl[15] = '{4'd4,  32'h104, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0, 2, 0, 4'h0, 32'h0};
        tbl[16] = '{4'd0,  32'h101, 32'h0,        32'h0,        32'hFFFFFFC5, 1'b0, 2, 0, 4'h0, 32'h0};

        init_mem();
        reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0;
        req_wdata = 32'd0; req_rt_old = 32'd0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_write",  32'(mem_write),  32'd0);
        check("rst_mem_addr",   mem_address,     32'd0);
        check("rst_mem_be",     32'(mem_byte_en), 32'd0);
        check("rst_mem_wd",     mem_writedata,   32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Leave a nonzero response behind so the reset below has something to clear
        do_req(4'd4, 32'h100, 32'h0, 32'h0, rd, flt, lat, nwr);
        check("pre_lw_rdata", rd, 32'h8899AABB);

        // Reset asserted mid-way through the ACCESS cycle of a store
        wc0 = wr_cnt;
        req_op = 4'd10; req_addr = 32'h100; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rs_mem_write_on", 32'(mem_write),   32'd1);
        check("rs_mem_addr",     mem_address,      32'h100);
        check("rs_mem_be",       32'(mem_byte_en), 32'hF);
        check("rs_mem_wd",       mem_writedata,    32'hDEADBEEF);
        #2 reset = 1'b1;
        #1;
        check("rs_mem_write_off", 32'(mem_write),   32'd0);
        check("rs_req_ready",     32'(req_ready),   32'd1);
        check("rs_resp_valid",    32'(resp_valid),  32'd0);
        check("rs_resp_rdata",    resp_rdata,       32'd0);
        check("rs_mem_addr0",     mem_address,      32'd0);
        check("rs_mem_be0",       32'(mem_byte_en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rs_mem_word", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'h8899AABB);
        check("rs_wr_cnt", 32'(wr_cnt - wc0), 32'd0);
        do_req(4'd4, 32'h100, 32'h0, 32'h0, rd, flt, lat, nwr);
        check("rs_lw_after", rd, 32'h8899AABB);

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            ref_model(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rt, erd, ef, el, en);
            do_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rt, rd, flt, lat, nwr);
            check($sformatf("v%0d_rdata", i), rd,           tbl[i].exp_rd);
            check($sformatf("v%0d_fault", i), 32'(flt),     32'(tbl[i].exp_f));
            check($sformatf("v%0d_lat", i),   32'(lat),     32'(tbl[i].exp_lat));
            check($sformatf("v%0d_nwr", i),   32'(nwr),     32'(tbl[i].exp_nwr));
            if (tbl[i].exp_nwr == 1) begin
                check($sformatf("v%0d_waddr", i), wr_addr,     {tbl[i].addr[31:2], 2'b00});
                check($sformatf("v%0d_wbe", i),   32'(wr_be),  32'(tbl[i].exp_be));
                check($sformatf("v%0d_wwd", i),   wr_wd,       tbl[i].exp_wd);
            end
        end

        // Backpressure: response frozen while resp_ready is low, pending request waits
        resp_ready = 1'b0;
        ref_model(4'd4, 32'h100, 32'h0, 32'h0, erd, ef, el, en);
        ref_model(4'd1, 32'h102, 32'h0, 32'h0, erd2, ef, el, en);
        req_op = 4'd4; req_addr = 32'h100; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 4'd1; req_addr = 32'h102;
        lat = 1;
        while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check("bp_lat", 32'(lat), 32'd2);
        check("bp_rdata0", resp_rdata, erd);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_valid%0d", c), 32'(resp_valid), 32'd1);
            check($sformatf("bp_rdata%0d", c), resp_rdata,      erd);
            check($sformatf("bp_ready%0d", c), 32'(req_ready),  32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", 32'(req_ready),  32'd1);
        check("bp_idle_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_accepted", 32'(req_ready), 32'd0);
        lat = 1;
        while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check("bp_next_lat",   32'(lat), 32'd2);
        check("bp_next_rdata", resp_rdata, erd2);
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            logic [3:0]  op;
            logic [31:0] addr, wd, rt;
            op   = 4'($urandom_range(0, 15));
            addr = 32'h100 + 32'($urandom_range(0, 15));
            wd   = $urandom;
            rt   = $urandom;
            ref_model(op, addr, wd, rt, erd, ef, el, en);
            do_req(op, addr, wd, rt, rd, flt, lat, nwr);
            check($sformatf("r%0d_op%0d_a%h_rdata", n, op, addr), rd,        erd);
            check($sformatf("r%0d_op%0d_fault", n, op),          32'(flt),  32'(ef));
            check($sformatf("r%0d_op%0d_lat", n, op),            32'(lat),  32'(el));
            check($sformatf("r%0d_op%0d_nwr", n, op),            32'(nwr),  32'(en));
        end

        for (int a = 12'h100; a < 12'h110; a++)
            check($sformatf("mem_%h", a), 32'(mem[a]), 32'(sh_mem[a]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit that acts as the initiator on the CPU's byte-addressed 32-bit data-memory port. It accepts one load or store request at a time from the MIPS datapath over a valid/ready handshake. It computes the word-aligned address, byte lanes, replicated write data and alignment faults, sequences the single-cycle memory access, then returns the sign/zero-extended or merged load result over a valid/ready response channel.

## Interface
- `OP_W`, 4: width of the operation code.
- `clk`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- `req_valid`  in  1  the datapath presents a request.
- `req_ready`  out  1  the block accepts a request; high only in IDLE.
- `req_op`  in  `OP_W`  LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10; any other code is illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from rt.
- `req_rt_old`  in  32  current rt value, used for the LWL/LWR merge.
- `resp_valid`  out  1  the response is valid.
- `resp_ready`  in  1  the datapath consumes the response.
- `resp_rdata`  out  32  load result; 0 for stores and faults.
- `resp_fault`  out  1  misaligned access or illegal op.
- `mem_address`  out  32  word-aligned byte address.
- `mem_write`  out  1  write strobe; memory commits on the rising edge.
- `mem_byte_en`  out  4  lane k selects `mem_writedata[8k+7:8k]`.
- `mem_writedata`  out  32  write data.
- `mem_readdata`  in  32  combinational read data; byte at offset k is in `[8k+7:8k]` (little-endian).

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. It resets to IDLE.
- **Capture:** on `req_valid && req_ready`, the block registers op, address, wdata and rt_old.
- **Fault check:**
  - LH, LHU and SH fault when `addr[0]` is 1.
  - LW and SW fault when `addr[1:0]` is not 0.
  - Illegal ops fault.
  - A faulting request goes IDLE→RESP with fault=1 and never enters ACCESS.
- **Legal requests:** IDLE→ACCESS (exactly one cycle)→RESP.
- **RESP:** the block holds the response until `resp_ready`, then returns to IDLE.
- **Memory outputs in ACCESS:** `mem_address = {addr[31:2],2'b00}`.
- **Memory outputs outside ACCESS:** `mem_address=0`, `mem_byte_en=0`, `mem_writedata=0` and `mem_write=0`.
- **Stores:** `mem_write=1` for exactly the ACCESS cycle.
  - SB: `byte_en = 1<<addr[1:0]`, `writedata = {4{wdata[7:0]}}`.
  - SH: `byte_en = addr[1] ? 4'b1100 : 4'b0011`, `writedata = {2{wdata[15:0]}}`.
  - SW: `byte_en = 4'b1111`, `writedata = wdata`.
- **Loads:** `byte_en` shows the lanes read (informational) and `mem_write=0`. `mem_readdata` is sampled at the end of ACCESS. With k=`addr[1:0]` and w=sampled word:
  - LB/LBU: byte k, sign/zero-extended.
  - LH/LHU: halfword `k[1]`, sign/zero-extended.
  - LW: w.
  - LWL: `(w << 8(3-k)) | (rt_old & (2^(8(3-k))-1))`.
  - LWR: `(w >> 8k) | (rt_old & ~(32'hFFFFFFFF >> 8k))`.
- **Response registers:** `resp_rdata` and `resp_fault` are registered. They stay stable throughout RESP.

## Timing
- **Reset values:** every output is 0, except `req_ready=1` (IDLE).
- **Latency:** a request accepted at edge N leads to ACCESS in cycle N..N+1 and `resp_valid` high from edge N+1 (fault case) or N+2 (legal case).
- **Throughput:** with `resp_ready` held high, a legal request completes every 3 cycles and a faulting one every 2. There is no overlap and no request is accepted in RESP.
- **Backpressure:** while `resp_ready=0`, `resp_*` are frozen and `req_ready=0`.
- **Reset mid-operation:** `reset` asserted during ACCESS deasserts `mem_write` asynchronously, before the next edge, so no partial store commits. The captured request is discarded.
- `req_*` are don't-care except at the accept edge.

## Structure
- Package `mips_lsu_pkg` holds:
  - the `lsu_op_t` enum (codes above);
  - the `lsu_state_t` enum (IDLE, ACCESS, RESP);
  - the functions `is_store` and `is_misaligned`.
- Sub-module `lsu_load_align` is a purely combinational block. It takes (op, k, w, rt_old) and produces the 32-bit load result. It is instantiated once and unit-tested separately.
- The FSM, capture registers and store-lane logic live in `mips_lsu`.

## Test plan
All scenarios use a memory model with byte-addressed storage, combinational read and write on the clock edge. Preload bytes 0x100..0x103 = BB, AA, 99, 88 (word 0x8899AABB).
1. **Byte loads:** LB 0x103 → `resp_rdata=0xFFFFFF88`, and `resp_valid` rises 2 cycles after accept. LBU 0x103 → `0x00000088`. LH 0x102 → `0xFFFF8899`.
2. **Halfword store:** SH 0x102 with wdata 0x00001234 → a single cycle with `mem_write=1`, `mem_address=0x100`, `byte_en=1100`, `writedata=0x12341234`. A following LW 0x100 → `0x1234AABB`.
3. **Faults:** LW 0x101 and SH 0x103 → `resp_fault=1`, `resp_rdata=0`, `resp_valid` 1 cycle after accept, and `mem_write` never asserted. Op 7 → fault.
4. **LWL/LWR merge:** with `rt_old=0x11223344`, LWL 0x101 → `0xAABB3344`, and LWR 0x102 → `0x11228899`.
5. **Backpressure:** hold `resp_ready=0` for 4 cycles after an LW → `resp_valid` stays high, `resp_rdata` is stable and `req_ready=0`. The next request is accepted the cycle after the handshake.
6. **Reset during store:** assert `reset` mid-cycle during the ACCESS of SW 0x100 with 0xDEADBEEF → `mem_write` falls at once, memory still reads 0x8899AABB, and the outputs show reset values.
